rom_dl_sequencer: RTL
=====================

// Module: rom_dl_sequencer
// PURPOSE
// - Sequences the HPS ioctl ROM download stream into the Tapper memory map: main/sound bytes to
//   SDRAM port1, sprite bytes to SDRAM port2 (32-bit word merge), BG bytes to the BRAM loader.
// - Replaces the free-running toggle logic with an ack-checked handshake plus ioctl_wait
//   backpressure, so SDRAM writes cannot be dropped. Also owns rom_loaded and the post-load core reset.
// PARAMETERS
// - SP_BASE   25'h12000  first sprite-ROM byte; addr < SP_BASE -> port1 (main 0000-DFFF, sound E000-11FFF)
// - BG_BASE   25'h32000  first BG-ROM byte; SP_BASE <= addr < BG_BASE -> port2
// - ROM_END   25'h3A000  first byte past the image; bytes >= ROM_END are discarded
// - RST_HOLD  16         width of the core_reset pulse (cycles) after download ends
// - TIMEOUT   1024       ack watchdog limit, cycles (used only with DL_TIMEOUT_EN)
// PORTS
// - clk_sys         in   1   system clock (40 MHz)
// - reset_n         in   1   asynchronous reset, active low
// - ioctl_download  in   1   download window active
// - ioctl_wr        in   1   byte strobe, one cycle; held-off while ioctl_wait=1
// - ioctl_addr      in   25  byte address
// - ioctl_dout      in   8   byte data
// - ioctl_wait      out  1   backpressure to hps_io
// - port1_req       out  1   toggle request, SDRAM port1
// - port1_ack       in   1   toggle ack; transfer complete when port1_ack==port1_req
// - port1_a         out  23  word address; port1_ds out 2 byte enables; port1_d out 16 write data
// - port2_req/port2_ack/port2_a[22:0]/port2_ds[1:0]/port2_d[15:0]  same for port2
// - dl_addr         out  25  BG byte address (addr-BG_BASE); dl_wr out 1 one-cycle strobe; dl_data out 8
// - rom_loaded      out  1   sticky: first full download completed
// - core_reset      out  1   active-high reset to Tapper core
// - dl_error        out  1   sticky ack-timeout flag (0 without DL_TIMEOUT_EN)
// BEHAVIOUR
// - Reset (async, reset_n=0): all outputs 0 except core_reset=1; state IDLE; buffer empty.
// - Capture: ioctl_wr=1 in IDLE latches addr/dout, classifies region (P1/P2/BG/DROP), -> ISSUE.
// - P1 mapping: port1_a=addr[23:1]; port1_ds={addr[0],~addr[0]}; port1_d={dout,dout}.
// - P2 mapping: off=addr-SP_BASE; port2_a={off[18:17],off[14:0],off[16]}; port2_ds={off[15],~off[15]}; port2_d={dout,dout}.
// - States: IDLE -> ISSUE -> WAIT_ACK -> IDLE.
//   - ISSUE (1 cycle): P1/P2 toggle the selected req only, -> WAIT_ACK; BG pulses dl_wr, -> IDLE;
//     DROP -> IDLE with no output activity.
//   - WAIT_ACK: stay until selected ack==req, then -> IDLE. a/ds/d stay stable from ISSUE to ack.
// - ioctl_wait=1 in ISSUE and WAIT_ACK; 0 in IDLE. Latency wr->req toggle = 1 cycle; wr->dl_wr = 1 cycle.
// - ioctl_wr while ioctl_wait=1 is a protocol violation: ignored, byte not captured.
// - Requests never issued while reset_n=0 or when ioctl_download=0 at capture time.
// - ioctl_download falling edge: in-flight transfer completes normally; when state returns to IDLE,
//   rom_loaded<=1 and core_reset held 1 for RST_HOLD cycles, then 0.
// - core_reset=1 whenever rom_loaded=0 or ioctl_download=1; a new download (rise) reasserts it.
// - Reset mid-transfer: req registers return to 0; SDRAM side is reset with the same reset_n.
// - Address wrap: addr-SP_BASE / addr-BG_BASE computed in 25 bits, used only inside their region.
// CONFIGURATION
// - DL_TIMEOUT_EN defined: 16-bit counter runs in WAIT_ACK; reaching TIMEOUT forces -> IDLE,
//   sets dl_error (sticky until reset_n), req left as toggled. Cleared on each ISSUE.
// - DL_TIMEOUT_EN undefined: no counter; WAIT_ACK waits indefinitely; dl_error tied 0.
// TESTING
// - wr addr 0x0001 data 0xA5, ack after 3 cycles -> port1_req toggles, port1_a=0, ds=2'b10,
//   d=16'hA5A5, ioctl_wait high 4 cycles.
// - wr addr 0x12000+0x8000+0x10001 data 0x3C -> port2_a={2'b00,15'h0001,1'b1}, ds=2'b10, port1_req unchanged.
// - wr addr 0x32010 data 0x77 -> dl_addr=0x10, dl_data=0x77, dl_wr high exactly 1 cycle, no req toggles.
// - wr addr 0x3A000 -> no req toggle, no dl_wr, ioctl_wait high 1 cycle only.
// - download falls during WAIT_ACK -> rom_loaded rises after ack; core_reset low after RST_HOLD=16 cycles.
// - DL_TIMEOUT_EN, ack withheld -> return to IDLE after 1024 cycles, dl_error=1 until reset_n pulse.

Source files
------------

// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer: routes ioctl bytes to SDRAM port1/port2 (toggle handshake) or the BG loader.
// Optional ack watchdog enabled by defining DL_TIMEOUT_EN.
module rom_dl_sequencer #(
  parameter logic [24:0] SP_BASE  = 25'h12000,
  parameter logic [24:0] BG_BASE  = 25'h32000,
  parameter logic [24:0] ROM_END  = 25'h3A000,
  parameter int          RST_HOLD = 16,
  parameter int          TIMEOUT  = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic [24:0] dl_addr,
  output logic        dl_wr,
  output logic [7:0]  dl_data,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        dl_error
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;

  localparam logic [1:0] R_P1   = 2'd0;
  localparam logic [1:0] R_P2   = 2'd1;
  localparam logic [1:0] R_BG   = 2'd2;
  localparam logic [1:0] R_DROP = 2'd3;

  logic [1:0]  state;
  logic [1:0]  region;
  logic [24:0] buf_addr;
  logic [7:0]  buf_data;
  logic [24:0] sp_off;
  logic [24:0] bg_off;
  logic        ack_match;
  logic        dl_prev;
  logic        load_pending;
  logic [15:0] hold_cnt;

`ifdef DL_TIMEOUT_EN
  logic [15:0] to_cnt;
`else
  assign dl_error = 1'b0;
`endif

  function automatic logic [1:0] classify(input logic [24:0] a);
    if (a < SP_BASE)      return R_P1;
    else if (a < BG_BASE) return R_P2;
    else if (a < ROM_END) return R_BG;
    else                  return R_DROP;
  endfunction

  // Offsets wrap in 25 bits; each is only consumed inside its own region.
  assign sp_off     = buf_addr - SP_BASE;
  assign bg_off     = buf_addr - BG_BASE;
  assign ack_match  = (region == R_P1) ? (port1_ack == port1_req) : (port2_ack == port2_req);
  assign ioctl_wait = (state != IDLE);
  assign core_reset = !rom_loaded || ioctl_download || (hold_cnt != 16'd0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      region       <= R_DROP;
      buf_addr     <= '0;
      buf_data     <= '0;
      port1_req    <= 1'b0;
      port1_a      <= '0;
      port1_ds     <= '0;
      port1_d      <= '0;
      port2_req    <= 1'b0;
      port2_a      <= '0;
      port2_ds     <= '0;
      port2_d      <= '0;
      dl_addr      <= '0;
      dl_wr        <= 1'b0;
      dl_data      <= '0;
      rom_loaded   <= 1'b0;
      dl_prev      <= 1'b0;
      load_pending <= 1'b0;
      hold_cnt     <= '0;
`ifdef DL_TIMEOUT_EN
      to_cnt       <= '0;
      dl_error     <= 1'b0;
`endif
    end else begin
      dl_wr   <= 1'b0;
      dl_prev <= ioctl_download;
      if (hold_cnt != 16'd0) hold_cnt <= hold_cnt - 16'd1;

      // Completion waits for the sequencer to drain so the last byte lands before the core restarts.
      if (!ioctl_download && dl_prev) begin
        load_pending <= 1'b1;
      end else if (ioctl_download) begin
        load_pending <= 1'b0;
      end else if (load_pending && state == IDLE) begin
        load_pending <= 1'b0;
        rom_loaded   <= 1'b1;
        hold_cnt     <= 16'(RST_HOLD);
      end

      case (state)
        IDLE: begin
          if (ioctl_wr && ioctl_download) begin
            buf_addr <= ioctl_addr;
            buf_data <= ioctl_dout;
            region   <= classify(ioctl_addr);
            state    <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef DL_TIMEOUT_EN
          to_cnt <= '0;
`endif
          case (region)
            R_P1: begin
              port1_a   <= buf_addr[23:1];
              port1_ds  <= {buf_addr[0], ~buf_addr[0]};
              port1_d   <= {buf_data, buf_data};
              port1_req <= ~port1_req;
              state     <= WAIT_ACK;
            end
            R_P2: begin
              port2_a   <= {5'd0, sp_off[18:17], sp_off[14:0], sp_off[16]};
              port2_ds  <= {sp_off[15], ~sp_off[15]};
              port2_d   <= {buf_data, buf_data};
              port2_req <= ~port2_req;
              state     <= WAIT_ACK;
            end
            R_BG: begin
              dl_addr <= bg_off;
              dl_data <= buf_data;
              dl_wr   <= 1'b1;
              state   <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
        WAIT_ACK: begin
          if (ack_match) begin
            state <= IDLE;
`ifdef DL_TIMEOUT_EN
          end else if (to_cnt == 16'(TIMEOUT - 1)) begin
            state    <= IDLE;
            dl_error <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
